// File: rtl/apb_req_arbiter_if.sv
// Request/response and APB observation bundle between the requesters and apb_req_arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters/bus side.
interface apb_req_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ*STRB_W-1:0] req_strb;
  logic [NUM_REQ-1:0]        req_done;
  logic                      req_err;
  logic [DATA_W-1:0]         req_rdata;
  logic [NUM_REQ-1:0]        grant;

  logic                      m_transfer;
  logic                      m_write;
  logic [ADDR_W-1:0]         m_addr;
  logic [DATA_W-1:0]         m_wdata;
  logic [STRB_W-1:0]         m_strb;

  logic                      PSEL;
  logic                      PENABLE;
  logic                      PREADY;
  logic                      PSLVERR;
  logic [DATA_W-1:0]         PRDATA;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_strb,
    input  PSEL, PENABLE, PREADY, PSLVERR, PRDATA,
    output req_done, req_err, req_rdata, grant,
    output m_transfer, m_write, m_addr, m_wdata, m_strb
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_strb,
    output PSEL, PENABLE, PREADY, PSLVERR, PRDATA,
    input  req_done, req_err, req_rdata, grant,
    input  m_transfer, m_write, m_addr, m_wdata, m_strb
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Shares one APB master between NUM_REQ requesters, one transfer at a time.
// Round robin by default; define APB_ARB_FIXED_PRIO_EN for lowest-index fixed priority.
module apb_req_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  apb_req_arbiter_if.slave      io_bus
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  state_t              r_state, w_state_nxt;

  logic [NUM_REQ-1:0]  r_grant, w_grant_nxt;
  logic [NUM_REQ-1:0]  r_req_done, w_req_done_nxt;
  logic                r_req_err, w_req_err_nxt;
  logic [DATA_W-1:0]   r_req_rdata, w_req_rdata_nxt;
  logic                r_m_transfer, w_m_transfer_nxt;
  logic                r_m_write, w_m_write_nxt;
  logic [ADDR_W-1:0]   r_m_addr, w_m_addr_nxt;
  logic [DATA_W-1:0]   r_m_wdata, w_m_wdata_nxt;
  logic [STRB_W-1:0]   r_m_strb, w_m_strb_nxt;

  logic                w_any_valid;
  logic                w_complete;
  logic [IDX_W-1:0]    w_win_idx;
  logic                w_sel_write;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic [STRB_W-1:0]   w_sel_strb;
  int unsigned         w_dist;
  int unsigned         w_best;

`ifndef APB_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]    r_last_grant, w_last_grant_nxt;
  logic [IDX_W-1:0]    r_owner, w_owner_nxt;
`endif

  assign w_any_valid = |io_bus.req_valid;
  assign w_complete  = io_bus.PSEL & io_bus.PENABLE & io_bus.PREADY;

  // Winner = valid requester with the smallest priority distance; its command is muxed alongside.
  always_comb begin
    w_win_idx   = '0;
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_strb  = '0;
    w_best      = NUM_REQ;
    w_dist      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
`ifdef APB_ARB_FIXED_PRIO_EN
      w_dist = i;
`else
      w_dist = (i + NUM_REQ - 32'(r_last_grant) - 32'd1) % NUM_REQ;
`endif
      if (io_bus.req_valid[i] && (w_dist < w_best)) begin
        w_best      = w_dist;
        w_win_idx   = IDX_W'(i);
        w_sel_write = io_bus.req_write[i];
        w_sel_addr  = io_bus.req_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = io_bus.req_wdata[i*DATA_W +: DATA_W];
        w_sel_strb  = io_bus.req_strb[i*STRB_W +: STRB_W];
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_any_valid) w_state_nxt = ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT:  if (w_complete) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; the m_* command holds between captures.
  always_comb begin
    w_grant_nxt      = r_grant;
    w_req_done_nxt   = '0;
    w_req_err_nxt    = r_req_err;
    w_req_rdata_nxt  = r_req_rdata;
    w_m_transfer_nxt = 1'b0;
    w_m_write_nxt    = r_m_write;
    w_m_addr_nxt     = r_m_addr;
    w_m_wdata_nxt    = r_m_wdata;
    w_m_strb_nxt     = r_m_strb;
`ifndef APB_ARB_FIXED_PRIO_EN
    w_last_grant_nxt = r_last_grant;
    w_owner_nxt      = r_owner;
`endif
    unique case (r_state)
      ST_IDLE: begin
        w_grant_nxt = '0;
        if (w_any_valid) begin
          w_grant_nxt      = NUM_REQ'(1) << w_win_idx;
          w_m_transfer_nxt = 1'b1;
          w_m_write_nxt    = w_sel_write;
          w_m_addr_nxt     = w_sel_addr;
          w_m_wdata_nxt    = w_sel_wdata;
          w_m_strb_nxt     = w_sel_strb;
`ifndef APB_ARB_FIXED_PRIO_EN
          w_owner_nxt      = w_win_idx;
`endif
        end
      end
      ST_ISSUE: ;
      ST_WAIT: begin
        if (w_complete) begin
          w_req_done_nxt  = r_grant;
          w_req_err_nxt   = io_bus.PSLVERR;
          w_req_rdata_nxt = io_bus.PRDATA;
        end
      end
      ST_DONE: begin
        w_grant_nxt = '0;
`ifndef APB_ARB_FIXED_PRIO_EN
        w_last_grant_nxt = r_owner;
`endif
      end
      default: w_grant_nxt = '0;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_grant      <= '0;
      r_req_done   <= '0;
      r_req_err    <= 1'b0;
      r_req_rdata  <= '0;
      r_m_transfer <= 1'b0;
      r_m_write    <= 1'b0;
      r_m_addr     <= '0;
      r_m_wdata    <= '0;
      r_m_strb     <= '0;
`ifndef APB_ARB_FIXED_PRIO_EN
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_owner      <= '0;
`endif
    end else begin
      r_grant      <= w_grant_nxt;
      r_req_done   <= w_req_done_nxt;
      r_req_err    <= w_req_err_nxt;
      r_req_rdata  <= w_req_rdata_nxt;
      r_m_transfer <= w_m_transfer_nxt;
      r_m_write    <= w_m_write_nxt;
      r_m_addr     <= w_m_addr_nxt;
      r_m_wdata    <= w_m_wdata_nxt;
      r_m_strb     <= w_m_strb_nxt;
`ifndef APB_ARB_FIXED_PRIO_EN
      r_last_grant <= w_last_grant_nxt;
      r_owner      <= w_owner_nxt;
`endif
    end
  end

  assign io_bus.grant      = r_grant;
  assign io_bus.req_done   = r_req_done;
  assign io_bus.req_err    = r_req_err;
  assign io_bus.req_rdata  = r_req_rdata;
  assign io_bus.m_transfer = r_m_transfer;
  assign io_bus.m_write    = r_m_write;
  assign io_bus.m_addr     = r_m_addr;
  assign io_bus.m_wdata    = r_m_wdata;
  assign io_bus.m_strb     = r_m_strb;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: APB master/slave stand-in plus a rule-level arbitration model.
module tb_apb_req_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STRB_W  = DATA_W / 8;

  logic PCLK;
  logic PRESETn;

  apb_req_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

  apb_req_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .io_bus  (bif)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_errors = 0;

  // APB master + slave stand-in: SETUP, then ACCESS with wait_cfg wait states.
  typedef enum logic [1:0] {B_IDLE, B_SETUP, B_ACCESS} bst_t;
  bst_t              bst;
  int                wait_left;
  int                wait_cfg = 0;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_write;

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      bst         <= B_IDLE;
      bif.PSEL    <= 1'b0;
      bif.PENABLE <= 1'b0;
      wait_left   <= 0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_write   <= 1'b0;
    end else begin
      case (bst)
        B_IDLE: if (bif.m_transfer) begin
          bst       <= B_SETUP;
          bif.PSEL  <= 1'b1;
          bus_addr  <= bif.m_addr;
          bus_wdata <= bif.m_wdata;
          bus_write <= bif.m_write;
        end
        B_SETUP: begin
          bst         <= B_ACCESS;
          bif.PENABLE <= 1'b1;
          wait_left   <= wait_cfg;
        end
        B_ACCESS: begin
          if (wait_left == 0) begin
            bst         <= B_IDLE;
            bif.PSEL    <= 1'b0;
            bif.PENABLE <= 1'b0;
          end else begin
            wait_left <= wait_left - 1;
          end
        end
        default: bst <= B_IDLE;
      endcase
    end
  end

  assign bif.PREADY = (bst == B_ACCESS) && (wait_left == 0);

  // Requester-side state kept by the bench.
  logic [NUM_REQ-1:0] vld;
  logic               rq_w [NUM_REQ];
  logic [ADDR_W-1:0]  rq_a [NUM_REQ];
  logic [DATA_W-1:0]  rq_d [NUM_REQ];
  logic [STRB_W-1:0]  rq_s [NUM_REQ];
  int                 m_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
    rq_w[i] = w; rq_a[i] = a; rq_d[i] = d; rq_s[i] = s;
    bif.req_write[i]                 = w;
    bif.req_addr[i*ADDR_W +: ADDR_W] = a;
    bif.req_wdata[i*DATA_W +: DATA_W] = d;
    bif.req_strb[i*STRB_W +: STRB_W] = s;
  endtask

  task automatic set_valid(input logic [NUM_REQ-1:0] v);
    vld = v;
    bif.req_valid = v;
  endtask

  // Rule-level winner: round robin scans upward from the last winner; fixed priority takes the lowest.
  function automatic int model_winner(input logic [NUM_REQ-1:0] v);
    int j;
`ifdef APB_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      j = i;
      if (v[j[1:0]]) return j;
    end
`else
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (m_last + k) % NUM_REQ;
      if (v[j[1:0]]) return j;
    end
`endif
    return 0;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int i);
    return NUM_REQ'(1) << i;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, ".grant"},      64'(bif.grant),      64'd0);
    chk({tag, ".req_done"},   64'(bif.req_done),   64'd0);
    chk({tag, ".req_err"},    64'(bif.req_err),    64'd0);
    chk({tag, ".req_rdata"},  64'(bif.req_rdata),  64'd0);
    chk({tag, ".m_transfer"}, 64'(bif.m_transfer), 64'd0);
    chk({tag, ".m_write"},    64'(bif.m_write),    64'd0);
    chk({tag, ".m_addr"},     64'(bif.m_addr),     64'd0);
    chk({tag, ".m_wdata"},    64'(bif.m_wdata),    64'd0);
    chk({tag, ".m_strb"},     64'(bif.m_strb),     64'd0);
  endtask

  // Called at a negedge in IDLE with vld already driven; ends at the negedge of the IDLE after DONE.
  task automatic do_xfer(input string tag, input int waits, input logic [DATA_W-1:0] rdata,
                         input logic err, input bit drop, output int win);
    int                w, cyc, pulses;
    logic              ew;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    logic [STRB_W-1:0] es;
    w  = model_winner(vld);
    ew = rq_w[w]; ea = rq_a[w]; ed = rq_d[w]; es = rq_s[w];
    wait_cfg    = waits;
    bif.PRDATA  = rdata;
    bif.PSLVERR = err;
    @(posedge PCLK); @(negedge PCLK);
    chk({tag, ".grant"},      64'(bif.grant),      64'(onehot(w)));
    chk({tag, ".m_transfer"}, 64'(bif.m_transfer), 64'd1);
    chk({tag, ".m_write"},    64'(bif.m_write),    64'(ew));
    chk({tag, ".m_addr"},     64'(bif.m_addr),     64'(ea));
    chk({tag, ".m_wdata"},    64'(bif.m_wdata),    64'(ed));
    chk({tag, ".m_strb"},     64'(bif.m_strb),     64'(es));
    if (drop) begin
      vld[w] = 1'b0;
      set_valid(vld);
      set_req(w, ~ew, '0, ~ed, ~es);
    end
    cyc = 1; pulses = 1;
    while (bif.req_done == '0 && cyc < 40) begin
      @(negedge PCLK);
      cyc++;
      if (bif.m_transfer) pulses++;
    end
    chk({tag, ".latency"},     64'(cyc),           64'(4 + waits));
    chk({tag, ".pulses"},      64'(pulses),        64'd1);
    chk({tag, ".req_done"},    64'(bif.req_done),  64'(onehot(w)));
    chk({tag, ".req_err"},     64'(bif.req_err),   64'(err));
    chk({tag, ".req_rdata"},   64'(bif.req_rdata), 64'(rdata));
    chk({tag, ".bus_addr"},    64'(bus_addr),      64'(ea));
    chk({tag, ".bus_wdata"},   64'(bus_wdata),     64'(ed));
    chk({tag, ".bus_write"},   64'(bus_write),     64'(ew));
    chk({tag, ".m_addr_hold"}, 64'(bif.m_addr),    64'(ea));
    @(negedge PCLK);
    chk({tag, ".done_clear"},  64'(bif.req_done),  64'd0);
    chk({tag, ".grant_clear"}, 64'(bif.grant),     64'd0);
`ifndef APB_ARB_FIXED_PRIO_EN
    m_last = w;
`endif
    win = w;
  endtask

  task automatic do_reset();
    PRESETn = 1'b0;
    m_last  = NUM_REQ - 1;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
  endtask

  initial begin
    int w;
    int exp_order [5];
    PRESETn       = 1'b0;
    bif.req_valid = '0;
    bif.req_write = '0;
    bif.req_addr  = '0;
    bif.req_wdata = '0;
    bif.req_strb  = '0;
    bif.PRDATA    = '0;
    bif.PSLVERR   = 1'b0;
    vld           = '0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, '0, '0, '0);

    // Reset values
    m_last = NUM_REQ - 1;
    repeat (2) @(negedge PCLK);
    chk_all_zero("reset");
    PRESETn = 1'b1;

    // Idle with nothing requested
    repeat (3) begin
      @(negedge PCLK);
      chk("idle.m_transfer", 64'(bif.m_transfer), 64'd0);
      chk("idle.grant",      64'(bif.grant),      64'd0);
    end

    // Single write from requester 0
    set_req(0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    set_valid(4'b0001);
    do_xfer("t1", 0, 32'h0, 1'b0, 1'b0, w);
    chk("t1.winner", 64'(w), 64'd0);
    set_valid(4'b0000);

    // Continuous full request from reset
    do_reset();
    for (int i = 0; i < NUM_REQ; i++)
      set_req(i, i[0], 32'h1000 + 32'(i) * 32'h10, $urandom, 4'(i + 1));
`ifdef APB_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    set_valid(4'b1111);
    for (int n = 0; n < 5; n++) begin
      do_xfer("t2", 0, $urandom, 1'b0, 1'b0, w);
      chk("t2.order", 64'(w), 64'(exp_order[n]));
    end
    set_valid(4'b0000);

    // Read from requester 2 with three wait states
    set_req(2, 1'b0, 32'h2000, 32'h0, 4'h0);
    set_valid(4'b0100);
    do_xfer("t3", 3, 32'h12345678, 1'b0, 1'b0, w);
    set_valid(4'b0000);

    // Slave error on requester 1, then a clean transfer
    set_req(1, 1'b1, 32'h3000, 32'hA5A5A5A5, 4'h3);
    set_valid(4'b0010);
    do_xfer("t4err", 1, 32'hBAD0BAD0, 1'b1, 1'b0, w);
    set_req(0, 1'b0, 32'h3004, 32'h0, 4'h0);
    set_valid(4'b0001);
    do_xfer("t4next", 0, 32'hCAFEF00D, 1'b0, 1'b0, w);
    set_valid(4'b0000);

    // Requester 3 withdraws and scribbles its command after the grant
    set_req(3, 1'b1, 32'h4440, 32'h0BADF00D, 4'hC);
    set_valid(4'b1000);
    do_xfer("t5", 2, 32'h0, 1'b0, 1'b1, w);
    set_valid(4'b0000);

    // Randomized traffic against the model
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < NUM_REQ; i++)
        set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      set_valid(4'($urandom_range(1, 15)));
      do_xfer("rand", $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)), 1'b0, w);
    end
    set_valid(4'b0000);

    // Reset in the middle of WAIT
    set_req(1, 1'b1, 32'h5000, 32'h11112222, 4'hF);
    set_valid(4'b0010);
    wait_cfg = 2;
    @(posedge PCLK); @(negedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b0;
    m_last  = NUM_REQ - 1;
    #1;
    chk_all_zero("t6rst");
    repeat (3) begin
      @(negedge PCLK);
      chk("t6rst.no_done", 64'(bif.req_done), 64'd0);
    end
    set_valid(4'b1111);
    PRESETn = 1'b1;
    do_xfer("t6after", 0, $urandom, 1'b0, 1'b0, w);
    chk("t6after.winner", 64'(w), 64'd0);
    set_valid(4'b0000);

    repeat (2) @(negedge PCLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Shares one APB master between NUM_REQ independent requesters (DMA, CPU bridge, debug port, ...).
- Sits in front of the APB master and drives its command inputs (SWRITE, SADDR, SWDATA, SSTRB, transfer).
- Observes the APB bus (PSEL, PENABLE, PREADY, PSLVERR, PRDATA) to detect completion, then returns status and read data to the granted requester.
- Runs one transfer at a time, with round-robin arbitration by default.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
- PCLK  in  1  clock
- PRESETn  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester command valid; held until own req_done
- req_write  in  NUM_REQ  per-requester direction (1 = write)
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies slice [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- req_strb  in  NUM_REQ*DATA_W/8  packed byte strobes
- req_done  out  NUM_REQ  one-hot, one-cycle completion pulse
- req_err  out  1  PSLVERR of the completed transfer; valid with req_done
- req_rdata  out  DATA_W  PRDATA of the completed transfer; valid with req_done
- grant  out  NUM_REQ  one-hot owner of the current transfer; 0 when idle
- m_transfer  out  1  to master transfer input
- m_write  out  1  to master SWRITE
- m_addr  out  ADDR_W  to master SADDR
- m_wdata  out  DATA_W  to master SWDATA
- m_strb  out  DATA_W/8  to master SSTRB
- PSEL, PENABLE, PREADY, PSLVERR  in  1 each  bus observation
- PRDATA  in  DATA_W  slave read data

Behaviour:
Reset (PRESETn low, asynchronous):
- State goes to IDLE.
- All outputs go to 0: grant, req_done, req_err, req_rdata, m_transfer, m_write, m_addr, m_wdata, m_strb.
- Round-robin pointer last_grant goes to NUM_REQ-1, so requester 0 wins first.
- Reset during ISSUE or WAIT abandons the transfer with no req_done. The master is reset by the same PRESETn.

All outputs are registered. States are IDLE, ISSUE, WAIT, DONE.

IDLE:
- If any req_valid is high, select winner w: the first set bit searching upward from last_grant+1, wrapping modulo NUM_REQ.
- At the same edge: latch grant = one-hot(w), and capture req_write/addr/wdata/strb[w] into the m_* registers. Next state is ISSUE.
- If no req_valid is high, stay in IDLE and drive m_transfer = 0.

ISSUE:
- m_transfer = 1 for exactly one cycle, then go to WAIT.

WAIT:
- m_transfer = 0, which prevents the master from chaining back-to-back transfers.
- Completion is PSEL & PENABLE & PREADY sampled high.
- On completion: capture PRDATA into req_rdata and PSLVERR into req_err, then go to DONE.
- Wait states (PREADY low) extend WAIT indefinitely.

DONE:
- req_done = grant for one cycle.
- last_grant = w.
- No arbitration takes place in this cycle.
- Next state is IDLE, where grant clears to 0.

Command stability and fairness:
- m_* outputs hold constant from capture until the next capture, and are unaffected by later req_* changes.
- If req_valid[w] drops while granted, the transfer still completes and req_done[w] still pulses.
- Minimum transfer spacing is 5 cycles (IDLE, ISSUE, SETUP/WAIT, ACCESS/WAIT, DONE).
- The earliest re-arbitration is the IDLE cycle after DONE, so a requester that sees req_done has one edge to drop or replace its command.
- Round robin guarantees each continuously requesting requester waits at most NUM_REQ-1 transfers.
- req_rdata and req_err are meaningful only in the DONE cycle. They hold their value until the next completion.
- A PSLVERR-terminated transfer completes normally with req_err = 1. The arbiter does not retry.

Optional Feature:
- Macro: APB_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest-index asserted req_valid always wins, and last_grant is unused.
- Undefined (default): round robin as described above.
- All other timing is identical in both builds.

Test Plan:
1. Reset, then req_valid = 4'b0001 with write, addr 0x100, wdata 0xDEADBEEF, strb 0xF, PREADY = 1. Required: m_transfer high for 1 cycle; bus sees addr 0x100 / data 0xDEADBEEF; req_done = 4'b0001 with req_err = 0 exactly 4 cycles after IDLE sampling.
2. req_valid = 4'b1111 held continuously. Required: grant order 0, 1, 2, 3, 0. With APB_ARB_FIXED_PRIO_EN defined, required order is 0, 0, 0.
3. Read from requester 2 with PREADY low for 3 ACCESS cycles and PRDATA = 0x12345678. Required: WAIT lasts 5 cycles; req_done = 4'b0100; req_rdata = 0x12345678.
4. Slave responds PSLVERR = 1 on requester 1. Required: req_err = 1 during the req_done[1] pulse; the next request proceeds normally.
5. Requester 3 drops req_valid and changes req_addr to 0x0 one cycle after grant. Required: bus still uses the captured address and req_done[3] still pulses.
6. PRESETn asserted in WAIT. Required: all outputs are 0 immediately, with no req_done. After release, requester 0 wins the first arbitration.
